// File: rtl/seq_pkg.sv
// Shared definitions for the serializer feeding the sequence-detector FSMs.
package seq_pkg;

    // Default word width for the serializer and its holding buffer.
    localparam int unsigned DEFAULT_WIDTH = 8;

    // ST_IDLE: shifter empty; ST_SHIFT: a data bit is currently on ser_out.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

endpackage

// File: rtl/seq_hold_buf.sv
// One-entry holding buffer that parks the next word while the shifter is busy.
module seq_hold_buf import seq_pkg::*; #(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full
);

    logic             full_d, full_q;
    logic [WIDTH-1:0] data_d, data_q;

    // Next state: a read empties the entry, a write fills it (never both in one cycle).
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (rd_en) begin
            full_d = 1'b0;
        end
        if (wr_en) begin
            full_d = 1'b1;
            data_d = wr_data;
        end
    end

    // Buffer state register; reset drops any parked word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign rd_data = data_q;
    assign full    = full_q;

endmodule

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial stage: valid/ready word input, one registered bit per clock out.
// A one-entry buffer lets consecutive words stream with no idle cycle between them.
module seq_bit_serializer import seq_pkg::*; #(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter bit          MSB_FIRST = 1'b1,
    parameter bit          IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_done
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    state_e           state_d, state_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic [WIDTH-1:0] shreg_d, shreg_q;
    logic             ser_out_d, ser_out_q;
    logic             ser_valid_d, ser_valid_q;
    logic             frame_done_d, frame_done_q;

    logic             buf_full;
    logic             buf_wr;
    logic             buf_rd;
    logic [WIDTH-1:0] buf_data;
    logic             accept;
    logic             load;
    logic [WIDTH-1:0] load_word;

    // Ready depends only on the buffer flop, never on data_valid.
    assign data_ready = !buf_full;
    assign accept     = data_valid & data_ready;

    seq_hold_buf #(
        .WIDTH (WIDTH)
    ) u_hold_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (buf_wr),
        .wr_data (data_in),
        .rd_en   (buf_rd),
        .rd_data (buf_data),
        .full    (buf_full)
    );

    // FSM next state, bit counter, shifter and registered serial outputs.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shreg_d      = shreg_q;
        ser_out_d    = IDLE_BIT;
        ser_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        buf_wr       = 1'b0;
        buf_rd       = 1'b0;
        load         = 1'b0;
        load_word    = data_in;

        unique case (state_q)
            ST_IDLE: begin
                // Empty shifter: the buffer is bypassed.
                if (accept) begin
                    load    = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cnt_q != '0) begin
                    // Mid-word: present the next bit, park any new word.
                    ser_valid_d  = 1'b1;
                    ser_out_d    = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
                    shreg_d      = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
                    cnt_d        = cnt_q - CNT_W'(1);
                    frame_done_d = (cnt_q == CNT_W'(1));
                    buf_wr       = accept;
                end else if (buf_full) begin
                    // Last bit on ser_out now; buffered word follows gaplessly.
                    load      = 1'b1;
                    load_word = buf_data;
                    buf_rd    = 1'b1;
                end else if (accept) begin
                    load = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A load puts the first bit out immediately and keeps the rest in the shifter.
        if (load) begin
            ser_valid_d = 1'b1;
            cnt_d       = CNT_W'(WIDTH - 1);
            ser_out_d   = MSB_FIRST ? load_word[WIDTH-1] : load_word[0];
            shreg_d     = MSB_FIRST ? (load_word << 1) : (load_word >> 1);
        end
    end

    // State and output registers; reset discards any word in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            shreg_q      <= '0;
            ser_out_q    <= IDLE_BIT;
            ser_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shreg_q      <= shreg_d;
            ser_out_q    <= ser_out_d;
            ser_valid_q  <= ser_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign ser_out    = ser_out_q;
    assign ser_valid  = ser_valid_q;
    assign frame_done = frame_done_q;

endmodule
